// File: rtl/ixc_assign_sched_8_if.sv
// Bundle of requester, grant and output-stage signals for ixc_assign_sched_8.
// The master side is the requester/downstream environment; the slave side is the scheduler.
interface ixc_assign_sched_8_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 8
);
    logic [NREQ-1:0] REQ;
    logic [NREQ-1:0] MASK;
    logic [W-1:0]    D0;
    logic [W-1:0]    D1;
    logic [W-1:0]    D2;
    logic [W-1:0]    D3;
    logic [NREQ-1:0] GNT;
    logic [W-1:0]    L;
    logic            LV;
    logic            LR;
    logic            BUSY;
    logic [7:0]      STALL;

    modport master (
        output REQ, MASK, D0, D1, D2, D3, LR,
        input  GNT, L, LV, BUSY, STALL
    );

    modport slave (
        input  REQ, MASK, D0, D1, D2, D3, LR,
        output GNT, L, LV, BUSY, STALL
    );
endinterface

// File: rtl/ixc_assign_sched_8.sv
// Round-robin scheduler: four requesters share one registered 8-bit assign path
// with a single-entry output stage and a saturating stall counter.
module ixc_assign_sched_8 #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 8
) (
    input logic                 CLK,
    input logic                 RST,
    ixc_assign_sched_8_if.slave bus
);
    typedef enum logic [1:0] {StEmpty, StFull, StHold} state_e;

    state_e          r_state;
    logic [1:0]      r_ptr;
    logic [W-1:0]    r_l;
    logic            r_lv;
    logic [7:0]      r_stall;

    logic [NREQ-1:0] w_elig;
    logic            w_take;
    logic            w_found;
    logic [1:0]      w_idx;
    logic [1:0]      w_win;
    logic [NREQ-1:0] w_gnt;
    logic [W-1:0]    w_data;

    assign w_elig = bus.REQ & ~bus.MASK;
    // Reset suppresses the grant so nothing looks granted while RST is high.
    assign w_take = ~RST & (~r_lv | bus.LR) & (|w_elig);

    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_win   = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            w_idx = r_ptr + 2'(k);
            if (!w_found && w_elig[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_comb begin
        w_gnt = '0;
        if (w_take) begin
            w_gnt[w_win] = 1'b1;
        end
    end

    always_comb begin
        w_data = '0;
        unique case (w_win)
            2'd0:    w_data = bus.D0;
            2'd1:    w_data = bus.D1;
            2'd2:    w_data = bus.D2;
            2'd3:    w_data = bus.D3;
            default: w_data = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= StEmpty;
            r_ptr   <= '0;
            r_l     <= '0;
            r_lv    <= 1'b0;
            r_stall <= '0;
        end else begin
            if (w_take) begin
                r_l     <= w_data;
                r_lv    <= 1'b1;
                r_ptr   <= w_win + 2'd1;
                r_state <= StFull;
            end else if (r_lv && bus.LR) begin
                r_lv    <= 1'b0;
                r_state <= StEmpty;
            end else if (r_lv) begin
                r_state <= StHold;
            end

            if (r_lv && !bus.LR) begin
                r_stall <= (r_stall != 8'hFF) ? r_stall + 8'd1 : r_stall;
            end else begin
                r_stall <= '0;
            end
        end
    end

    assign bus.GNT   = w_gnt;
    assign bus.L     = r_l;
    assign bus.LV    = r_lv;
    assign bus.BUSY  = r_lv;
    assign bus.STALL = r_stall;
endmodule

// File: tb/tb_ixc_assign_sched_8.sv
// Directed self-checking bench for ixc_assign_sched_8 with hand-computed expectations.
module tb_ixc_assign_sched_8;
    logic CLK;
    logic RST;
    int   n_vec;
    int   n_err;

    ixc_assign_sched_8_if #(.NREQ(4), .W(8)) bus ();

    ixc_assign_sched_8 #(.NREQ(4), .W(8)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST     = 1'b1;
        bus.REQ = 4'b0000;
        tick();
        tick();
        RST = 1'b0;
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        RST      = 1'b1;
        bus.REQ  = 4'b1111;
        bus.MASK = 4'b0000;
        bus.LR   = 1'b1;
        bus.D0   = 8'h10;
        bus.D1   = 8'h11;
        bus.D2   = 8'h12;
        bus.D3   = 8'h13;

        // Reset state with requests pending
        tick();
        tick();
        chk("rst_gnt", 32'(bus.GNT), 32'h0);
        chk("rst_l", 32'(bus.L), 32'h00);
        chk("rst_lv", 32'(bus.LV), 32'h0);
        chk("rst_busy", 32'(bus.BUSY), 32'h0);
        chk("rst_stall", 32'(bus.STALL), 32'h0);
        chk("rst_ptr", 32'(dut.r_ptr), 32'h0);

        // Single request from requester 2, then one-cycle valid
        RST     = 1'b0;
        bus.REQ = 4'b0100;
        bus.D2  = 8'hA5;
        bus.LR  = 1'b1;
        #1;
        chk("single_gnt", 32'(bus.GNT), 32'h4);
        tick();
        chk("single_l", 32'(bus.L), 32'hA5);
        chk("single_lv", 32'(bus.LV), 32'h1);
        chk("single_ptr", 32'(dut.r_ptr), 32'h3);
        bus.REQ = 4'b0000;
        #1;
        chk("single_gnt_idle", 32'(bus.GNT), 32'h0);
        tick();
        chk("single_lv_drop", 32'(bus.LV), 32'h0);
        chk("single_l_keep", 32'(bus.L), 32'hA5);
        chk("single_busy_drop", 32'(bus.BUSY), 32'h0);

        // Full-throughput rotation across all four requesters
        do_reset();
        bus.D2  = 8'h12;
        bus.REQ = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("rr_gnt%0d", i), 32'(bus.GNT), 32'(1 << (i % 4)));
            tick();
            chk($sformatf("rr_l%0d", i), 32'(bus.L), 32'h10 + 32'(i % 4));
            chk($sformatf("rr_lv%0d", i), 32'(bus.LV), 32'h1);
        end
        bus.REQ = 4'b0000;
        tick();
        chk("rr_drain_lv", 32'(bus.LV), 32'h0);
        chk("rr_ptr", 32'(dut.r_ptr), 32'h1);

        // Long stall: STALL saturates at 255, data and grant frozen
        do_reset();
        bus.D0  = 8'h3C;
        bus.REQ = 4'b0001;
        bus.LR  = 1'b0;
        tick();
        chk("stall_load_l", 32'(bus.L), 32'h3C);
        chk("stall_load_cnt", 32'(bus.STALL), 32'h0);
        for (int n = 1; n <= 300; n++) begin
            tick();
            if (n == 1 || n == 254 || n == 255 || n == 256 || n == 300)
                chk($sformatf("stall_cnt%0d", n), 32'(bus.STALL), (n > 255) ? 32'd255 : 32'(n));
            if (n == 150) begin
                chk("stall_gnt", 32'(bus.GNT), 32'h0);
                chk("stall_l", 32'(bus.L), 32'h3C);
                chk("stall_lv", 32'(bus.LV), 32'h1);
            end
        end
        chk("stall_l_end", 32'(bus.L), 32'h3C);
        bus.LR = 1'b1;
        #1;
        chk("stall_release_gnt", 32'(bus.GNT), 32'h1);
        tick();
        chk("stall_clear", 32'(bus.STALL), 32'h0);
        chk("stall_reload_lv", 32'(bus.LV), 32'h1);
        bus.REQ = 4'b0000;
        tick();

        // Masked arbitration, then unmask requester 0 mid-run
        do_reset();
        bus.D0   = 8'h10;
        bus.REQ  = 4'b1111;
        bus.MASK = 4'b0101;
        bus.LR   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("mask_gnt%0d", i), 32'(bus.GNT), (i % 2 == 0) ? 32'h2 : 32'h8);
            tick();
        end
        bus.MASK = 4'b0100;
        #1;
        chk("unmask_gnt0", 32'(bus.GNT), 32'h1);
        tick();
        chk("unmask_l0", 32'(bus.L), 32'h10);
        #1;
        chk("unmask_gnt1", 32'(bus.GNT), 32'h2);
        tick();
        #1;
        chk("unmask_gnt2", 32'(bus.GNT), 32'h8);
        tick();
        bus.MASK = 4'b0000;

        // Reset during a stalled word discards it
        do_reset();
        bus.REQ = 4'b0001;
        bus.LR  = 1'b0;
        tick();
        tick();
        chk("rsthold_pre_stall", 32'(bus.STALL), 32'h1);
        RST = 1'b1;
        #1;
        chk("rsthold_gnt", 32'(bus.GNT), 32'h0);
        tick();
        chk("rsthold_lv", 32'(bus.LV), 32'h0);
        chk("rsthold_l", 32'(bus.L), 32'h00);
        chk("rsthold_stall", 32'(bus.STALL), 32'h0);
        RST     = 1'b0;
        bus.REQ = 4'b1000;
        bus.LR  = 1'b1;
        #1;
        chk("rsthold_gnt3", 32'(bus.GNT), 32'h8);
        tick();
        chk("rsthold_l3", 32'(bus.L), 32'h13);
        chk("rsthold_ptr", 32'(dut.r_ptr), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ixc_assign_sched_8.md
IXC_ASSIGN_SCHED_8 -- requirements
Module: ixc_assign_sched_8

Interface
REQ-001 Parameter: NREQ, 4, number of requesters sharing the 8-bit assign path (fixed at 4 for this revision).
REQ-002 Parameter: W, 8, data width of the shared assign path.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 RST  input  1  reset; the block SHALL use a synchronous, active-high reset sampled on the rising edge of CLK.
REQ-005 REQ  input  4  per-requester request; REQ[i]=1 means D_i is valid and waiting.
REQ-006 MASK  input  4  per-requester disable; MASK[i]=1 excludes requester i from arbitration.
REQ-007 D0, D1, D2, D3  input  8 each  requester data.
REQ-008 GNT  output  4  one-hot grant, combinational, asserted only in the cycle the winner's data is captured.
REQ-009 L  output  8  registered data driven onto the shared assign path.
REQ-010 LV  output  1  L holds valid data.
REQ-011 LR  input  1  downstream ready; the transfer completes in any cycle where LV=1 and LR=1.
REQ-012 BUSY  output  1  equals LV (output stage occupied).
REQ-013 STALL  output  8  consecutive-cycle count of LV=1 with LR=0, saturating.

Function
REQ-014 The controller SHALL implement states EMPTY (LV=0), FULL (LV=1 with LR=1 expected) and HOLD (LV=1, LR=0 seen in the previous cycle); HOLD and FULL both drive LV=1.
REQ-015 eligible[i] = REQ[i] & ~MASK[i]; take = (~LV | LR) & |eligible.
REQ-016 Winner SHALL be the first eligible index found scanning PTR, PTR+1, ... mod 4 (round-robin).
REQ-017 On take: GNT[winner]=1 the same cycle; next edge L<=D_winner, LV<=1, PTR<=(winner+1) mod 4.
REQ-018 Without take, GNT SHALL be 4'b0000; GNT SHALL never have more than one bit set.
REQ-019 Latency: REQ asserted with stage EMPTY -> LV=1 with data on the following edge (1 cycle).
REQ-020 Back-to-back: with LV=1, LR=1 and an eligible request, a new word SHALL be loaded in the same cycle the old one completes (full throughput, no bubble).
REQ-021 LV=1, LR=1, no eligible request: LV<=0, L retains its last value, state -> EMPTY.
REQ-022 LV=1, LR=0: L and LV SHALL hold unchanged, GNT=0, state -> HOLD, STALL<=min(STALL+1,255).
REQ-023 STALL SHALL clear to 0 on any cycle that is not LV=1 & LR=0.
REQ-024 PTR SHALL be unchanged when no take occurs; wrap from 3 to 0 is modular.
REQ-025 MASK changes SHALL take effect in the same cycle; masking a requester already captured in L SHALL not affect the pending transfer.
REQ-026 All eligible requests simultaneously with PTR=k: requester k wins; starvation-free (each continuously eligible requester granted within 4 takes).
REQ-027 A requester de-asserting REQ in a cycle without its grant SHALL lose nothing (no state kept per requester).

Reset
REQ-028 While RST=1: L=8'h00, LV=0, BUSY=0, STALL=0, PTR=0, state EMPTY, GNT=0 regardless of REQ.
REQ-029 Reset asserted while FULL/HOLD SHALL discard the pending word; first grant after reset release follows PTR=0.
REQ-030 RST has priority over every other event in the same cycle.

Verification
REQ-031 Reset, then REQ=4'b0100, D2=8'hA5, LR=1 -> GNT=4'b0100 that cycle; next cycle L=8'hA5, LV=1, PTR=3.
REQ-032 REQ=4'b1111 held, LR=1, MASK=0, D_i=8'h10+i -> L sequence 8'h10,8'h11,8'h12,8'h13,8'h10, one word per cycle, GNT one-hot rotating.
REQ-033 LV=1, L=8'h3C, LR=0 for 300 cycles with REQ=4'b0001 -> L stays 8'h3C, GNT=0, STALL reaches 255 and holds; LR=1 -> requester 0 granted same cycle, STALL=0 next cycle.
REQ-034 REQ=4'b1111, MASK=4'b0101, PTR=0 -> grants alternate 1,3,1,3; unmask bit 0 mid-run -> 0 granted when PTR scan reaches it.
REQ-035 RST=1 asserted while LV=1 and LR=0 -> next cycle LV=0, L=8'h00, STALL=0; after release with REQ=4'b1000 -> GNT=4'b1000, L=D3, PTR=0.
REQ-036 Single word with LR=1 and no further requests -> LV high exactly one cycle, then 0 with L unchanged.
